// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial 32-bit ALU, one bit per cycle through a single 1-bit slice
module serial_alu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [3:0]  ALU_control,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        zero,
    output logic        cout,
    output logic        overflow
);
    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
    state_t state, next;
    logic [31:0] a, b, sh, final_res;
    logic [3:0]  op;
    logic [4:0]  cnt;
    logic        carry, c31, is_sub, arith, a_inv, b_inv, ai, bi, sum_bit, carry_next, bit_out, ovf;

    // single 1-bit ALU slice; SUB/SLT run as A + ~B with carry preset to 1, NOR as ~A & ~B
    always_comb begin
        is_sub     = op == 4'b0110 || op == 4'b0111;
        arith      = is_sub || op == 4'b0010;
        a_inv      = op == 4'b1100;
        b_inv      = is_sub || a_inv;
        ai         = a[cnt] ^ a_inv;
        bi         = b[cnt] ^ b_inv;
        sum_bit    = ai ^ bi ^ carry;
        carry_next = (ai & bi) | (carry & (ai ^ bi));
        bit_out    = (op == 4'b0000 || a_inv) ? ai & bi :
                     op == 4'b0001 ? ai | bi :
                     arith ? sum_bit : 1'b0;
        ovf        = c31 ^ carry;
        final_res  = op == 4'b0111 ? {31'b0, sh[31] ^ ovf} : sh;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next;

    // next state: 32 CALC cycles, then one FINISH cycle
    always_comb begin
        next = state == IDLE   ? (start ? CALC : IDLE) :
               state == CALC   ? (cnt == 5'd31 ? FINISH : CALC) :
               IDLE;
    end

    // FSM outputs
    always_comb begin
        busy = state == CALC || state == FINISH;
    end

    // datapath: capture on accept, shift one bit per CALC cycle, publish results on leaving FINISH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a        <= '0;
            b        <= '0;
            op       <= '0;
            sh       <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            c31      <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= state == FINISH;
            if (state == IDLE && start) begin
                a     <= src1;
                b     <= src2;
                op    <= ALU_control;
                cnt   <= '0;
                carry <= ALU_control == 4'b0110 || ALU_control == 4'b0111;
            end else if (state == CALC) begin
                sh    <= {bit_out, sh[31:1]};
                carry <= carry_next;
                cnt   <= cnt + 5'd1;
                if (cnt == 5'd31) c31 <= carry;
            end else if (state == FINISH) begin
                result   <= final_res;
                zero     <= final_res == 32'd0;
                cout     <= arith & carry;
                overflow <= arith & ovf;
            end
        end
    end
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl: randomized and directed checks of serial_alu_ctrl against an arithmetic model
module tb_serial_alu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src1 = '0, src2 = '0;
    logic [3:0]  ALU_control = '0;
    logic        busy, done, zero, cout, overflow;
    logic [31:0] result;
    int          vectors = 0, errors = 0;

    serial_alu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src1(src1), .src2(src2),
        .ALU_control(ALU_control), .busy(busy), .done(done), .result(result),
        .zero(zero), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                  output logic [31:0] r, output logic c, output logic o);
        logic [32:0] s;
        r = '0; c = 1'b0; o = 1'b0;
        if (op == 4'b0000) r = a & b;
        else if (op == 4'b0001) r = a | b;
        else if (op == 4'b1100) r = ~(a | b);
        else if (op == 4'b0010) begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0]; c = s[32];
            o = (a[31] == b[31]) && (r[31] != a[31]);
        end else if (op == 4'b0110 || op == 4'b0111) begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r = s[31:0]; c = s[32];
            o = (a[31] != b[31]) && (r[31] != a[31]);
            if (op == 4'b0111) r = {31'b0, $signed(a) < $signed(b)};
        end
    endfunction

    logic [31:0] last_res;

    // apply one operation with noise on inputs while busy; checks latency, busy, single done, outputs
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [31:0] er;
        logic        ec, eo;
        int          lat;
        model(a, b, op, er, ec, eo);
        @(negedge clk);
        src1 = a; src2 = b; ALU_control = op; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                start = 1'b0;
                break;
            end
            check("done_early", 32'(done), 32'd0);
            if (i == 1 || i == 17 || i == 32) check("busy_calc", 32'(busy), 32'd1);
            src1 = $urandom; src2 = $urandom; ALU_control = 4'($urandom);
            start = 1'($urandom_range(0, 1));
        end
        check("latency", 32'(lat), 32'd33);
        check("busy_after", 32'(busy), 32'd0);
        check("result", result, er);
        check("zero", 32'(zero), 32'(er == 32'd0));
        check("cout", 32'(cout), 32'(ec));
        check("overflow", 32'(overflow), 32'(eo));
        last_res = er;
    endtask

    // one idle cycle after done: pulse must end, outputs must hold
    task automatic idle_check();
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd0);
        check("hold", result, last_res);
    endtask

    initial begin
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {29'd0, zero, cout, overflow}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_op(32'h7FFFFFFF, 32'h00000001, 4'b0010);
        idle_check();
        run_op(32'd5, 32'd5, 4'b0110);
        run_op(32'h80000000, 32'd1, 4'b0111);
        run_op(32'd1, 32'hFFFFFFFF, 4'b0111);
        run_op(32'hF0F0F0F0, 32'hFF00FF00, 4'b0000);
        run_op(32'hF0F0F0F0, 32'hFF00FF00, 4'b0001);
        run_op(32'hF0F0F0F0, 32'hFF00FF00, 4'b1100);
        idle_check();
        run_op(32'h12345678, 32'h9ABCDEF0, 4'b0011);
        repeat (3) idle_check();
        for (int k = 0; k < 24; k++) begin
            logic [3:0] ops [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1010};
            logic [31:0] x, y;
            x = $urandom; y = $urandom;
            if (k % 5 == 0) y = x;
            run_op(x, y, ops[$urandom_range(0, 6)]);
        end
        run_op(32'hDEADBEEF, 32'h11111111, 4'b0001);
        @(negedge clk);
        src1 = 32'd100; src2 = 32'd200; ALU_control = 4'b0010; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_flags", {29'd0, zero, cout, overflow}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_op(32'd3, 32'd4, 4'b0010);
        idle_check();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
